// File: rtl/apb_plic_target.sv
// APB3 platform-level interrupt controller for a single hart context: per-source
// priority/enable/gateway, claim/complete, threshold. APB_PLIC_SLVERR_EN enables pslverr_o.
module apb_plic_target #(
    parameter int NIrqSrcs  = 8,
    parameter int PrioWidth = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [11:0]         paddr_i,
    input  logic [31:0]         pwdata_i,
    output logic [31:0]         prdata_o,
    output logic                pready_o,
    output logic                pslverr_o,
    input  logic [NIrqSrcs-1:0] irq_src_i,
    output logic                irq_o
);

    logic [PrioWidth-1:0] prio_r [1:NIrqSrcs];
    logic [NIrqSrcs:1]    enable_r;
    logic [NIrqSrcs:1]    pending_r;
    logic [NIrqSrcs:1]    inflight_r;
    logic [PrioWidth-1:0] threshold_r;
    logic                 irq_r;

    logic                 access_s;
    logic                 rd_s;
    logic                 wr_s;
    logic [9:0]           word_s;
    logic                 prio_sel_s;
    logic [4:0]           prio_idx_s;
    logic                 pend_sel_s;
    logic                 en_sel_s;
    logic                 thr_sel_s;
    logic                 claim_sel_s;
    logic                 claim_rd_s;
    logic [4:0]           win_id_s;
    logic [PrioWidth-1:0] win_prio_s;
    logic                 win_valid_s;
    logic                 take_s;
    logic [31:0]          rdata_s;
    logic                 unused_s;

    assign access_s    = psel_i & penable_i;
    assign rd_s        = access_s & ~pwrite_i;
    assign wr_s        = access_s & pwrite_i;
    assign word_s      = paddr_i[11:2];
    assign prio_sel_s  = (paddr_i[11:7] == 5'd0);
    assign prio_idx_s  = paddr_i[6:2];
    assign pend_sel_s  = (word_s == 10'h020);
    assign en_sel_s    = (word_s == 10'h040);
    assign thr_sel_s   = (word_s == 10'h080);
    assign claim_sel_s = (word_s == 10'h081);
    assign claim_rd_s  = rd_s & claim_sel_s;
    assign unused_s    = ^paddr_i[1:0];

    // Winner search: strict compare in ascending ID order keeps the lowest ID on ties,
    // and starting from priority 0 means a priority-0 source can never win.
    always_comb begin
        win_id_s   = 5'd0;
        win_prio_s = '0;
        take_s     = 1'b0;
        for (int k = 1; k <= NIrqSrcs; k++) begin
            take_s     = pending_r[k] & enable_r[k] & (prio_r[k] > threshold_r) &
                         (prio_r[k] > win_prio_s);
            win_id_s   = take_s ? 5'(k) : win_id_s;
            win_prio_s = take_s ? prio_r[k] : win_prio_s;
        end
        win_valid_s = (win_id_s != 5'd0);
    end

    // Read data mux; driven only during a read access cycle outside reset.
    always_comb begin
        rdata_s = 32'd0;
        if (rd_s && !rst_i) begin
            if (prio_sel_s) begin
                for (int k = 1; k <= NIrqSrcs; k++) begin
                    rdata_s[PrioWidth-1:0] = (prio_idx_s == 5'(k)) ? prio_r[k]
                                                                   : rdata_s[PrioWidth-1:0];
                end
            end else if (pend_sel_s) begin
                rdata_s[NIrqSrcs:1] = pending_r;
            end else if (en_sel_s) begin
                rdata_s[NIrqSrcs:1] = enable_r;
            end else if (thr_sel_s) begin
                rdata_s[PrioWidth-1:0] = threshold_r;
            end else if (claim_sel_s) begin
                rdata_s[4:0] = win_id_s;
            end else begin
                rdata_s = 32'd0;
            end
        end else begin
            rdata_s = 32'd0;
        end
    end

`ifdef APB_PLIC_SLVERR_EN
    localparam logic [4:0] MaxId = 5'(NIrqSrcs);
    logic mapped_s;
    logic err_s;

    // Error on unmapped addresses and on writes to the read-only pending bitmap.
    always_comb begin
        mapped_s = (prio_sel_s && (prio_idx_s <= MaxId)) || pend_sel_s || en_sel_s ||
                   thr_sel_s || claim_sel_s;
        if (access_s && !rst_i) begin
            err_s = ~mapped_s | (pwrite_i & pend_sel_s);
        end else begin
            err_s = 1'b0;
        end
    end

    assign pslverr_o = err_s;
`else
    assign pslverr_o = 1'b0;
`endif

    assign prdata_o = rdata_s;
    assign pready_o = 1'b1;
    assign irq_o    = irq_r;

    // Register file, gateways and claim/complete bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 1; k <= NIrqSrcs; k++) begin
                prio_r[k] <= '0;
            end
            enable_r    <= '0;
            pending_r   <= '0;
            inflight_r  <= '0;
            threshold_r <= '0;
            irq_r       <= 1'b0;
        end else begin
            for (int k = 1; k <= NIrqSrcs; k++) begin
                if (wr_s && prio_sel_s && (prio_idx_s == 5'(k))) begin
                    prio_r[k] <= pwdata_i[PrioWidth-1:0];
                end
                if (wr_s && en_sel_s) begin
                    enable_r[k] <= pwdata_i[k];
                end
                if (!pending_r[k] && !inflight_r[k] && irq_src_i[k-1]) begin
                    pending_r[k] <= 1'b1;
                end
                // A claim overrides the gateway; the old inflight value keeps a
                // same-edge complete from re-pending until the following edge.
                if (claim_rd_s && (win_id_s == 5'(k))) begin
                    pending_r[k]  <= 1'b0;
                    inflight_r[k] <= 1'b1;
                end else if (wr_s && claim_sel_s && (pwdata_i == 32'(k)) && inflight_r[k]) begin
                    inflight_r[k] <= 1'b0;
                end
            end
            if (wr_s && thr_sel_s) begin
                threshold_r <= pwdata_i[PrioWidth-1:0];
            end
            irq_r <= win_valid_s;
        end
    end

endmodule

// File: tb/tb_apb_plic_target.sv
// Directed self-checking bench for apb_plic_target (default 8 sources, 3-bit priority).
module tb_apb_plic_target;

    logic        clk_i;
    logic        rst_i;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [11:0] paddr_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic [7:0]  irq_src_i;
    logic        irq_o;

    int checks = 0;
    int errors = 0;

`ifdef APB_PLIC_SLVERR_EN
    localparam logic ExpErr = 1'b1;
`else
    localparam logic ExpErr = 1'b0;
`endif

    apb_plic_target #(.NIrqSrcs(8), .PrioWidth(3)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .psel_i    (psel_i),
        .penable_i (penable_i),
        .pwrite_i  (pwrite_i),
        .paddr_i   (paddr_i),
        .pwdata_i  (pwdata_i),
        .prdata_o  (prdata_o),
        .pready_o  (pready_o),
        .pslverr_o (pslverr_o),
        .irq_src_i (irq_src_i),
        .irq_o     (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        #1;
        err = pslverr_o;
        check("prdata_during_write", prdata_o, 32'd0);
        @(posedge clk_i); #1;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        logic e;
        apb_write(a, d, e);
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        #1;
        d   = prdata_o;
        err = pslverr_o;
        @(posedge clk_i); #1;
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(a, d, e);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        paddr_i = 12'h000; pwdata_i = 32'd0; irq_src_i = 8'h00;

        // Reset state
        @(posedge clk_i); #1;
        check("pready_in_reset", {31'd0, pready_o}, 32'd1);
        @(posedge clk_i); #1;
        check("irq_after_reset", {31'd0, irq_o}, 32'd0);
        rst_i = 1'b0;
        check("prdata_idle", prdata_o, 32'd0);
        rd_chk("rst_prio0", 12'h000, 32'd0);
        rd_chk("rst_prio1", 12'h004, 32'd0);
        rd_chk("rst_prio8", 12'h020, 32'd0);
        rd_chk("rst_pending", 12'h080, 32'd0);
        rd_chk("rst_enable", 12'h100, 32'd0);
        rd_chk("rst_threshold", 12'h200, 32'd0);
        rd_chk("rst_claim", 12'h204, 32'd0);
        check("rst_pready", {31'd0, pready_o}, 32'd1);

        // Single source: latency, claim, no re-pend, complete
        wr(12'h00C, 32'd2);
        wr(12'h100, 32'h09);
        wr(12'h200, 32'd1);
        rd_chk("prio3_rb", 12'h00C, 32'd2);
        rd_chk("enable_bit0_zero", 12'h100, 32'h08);
        rd_chk("threshold_rb", 12'h200, 32'd1);
        irq_src_i = 8'h04;
        @(posedge clk_i); #1;
        check("irq_after_edge_n", {31'd0, irq_o}, 32'd0);
        @(posedge clk_i); #1;
        check("irq_after_edge_n1", {31'd0, irq_o}, 32'd1);
        rd_chk("pending_src3", 12'h080, 32'h08);
        rd_chk("claim_3", 12'h204, 32'd3);
        check("irq_right_after_claim", {31'd0, irq_o}, 32'd1);
        @(posedge clk_i); #1;
        check("irq_drops_after_claim", {31'd0, irq_o}, 32'd0);
        rd_chk("pending_no_repend", 12'h080, 32'd0);
        wr(12'h204, 32'd3);
        check("irq_complete_edge", {31'd0, irq_o}, 32'd0);
        @(posedge clk_i); #1;
        check("irq_complete_plus1", {31'd0, irq_o}, 32'd0);
        @(posedge clk_i); #1;
        check("irq_complete_plus2", {31'd0, irq_o}, 32'd1);
        rd_chk("pending_repend", 12'h080, 32'h08);
        wr(12'h204, 32'd0);
        wr(12'h204, 32'd7);
        wr(12'h204, 32'd9);
        wr(12'h204, 32'd3);
        rd_chk("pending_bad_completes", 12'h080, 32'h08);
        rd_chk("claim_3_again", 12'h204, 32'd3);
        irq_src_i = 8'h00;
        wr(12'h204, 32'd3);
        rd_chk("pending_clear", 12'h080, 32'd0);

        // Priority order and lowest-ID tie break
        wr(12'h004, 32'd4);
        wr(12'h014, 32'd4);
        wr(12'h008, 32'd6);
        wr(12'h100, 32'h26);
        irq_src_i = 8'h13;
        rd_chk("pending_three", 12'h080, 32'h26);
        rd_chk("claim_order_2", 12'h204, 32'd2);
        rd_chk("claim_order_1", 12'h204, 32'd1);
        rd_chk("claim_order_5", 12'h204, 32'd5);
        rd_chk("claim_none", 12'h204, 32'd0);
        rd_chk("pending_all_claimed", 12'h080, 32'd0);
        check("irq_all_claimed", {31'd0, irq_o}, 32'd0);
        irq_src_i = 8'h00;
        wr(12'h204, 32'd2);
        wr(12'h204, 32'd1);
        wr(12'h204, 32'd5);
        rd_chk("pending_after_completes", 12'h080, 32'd0);
        irq_src_i = 8'h02;
        rd_chk("pending_src2_again", 12'h080, 32'h04);
        rd_chk("claim_2_again", 12'h204, 32'd2);
        irq_src_i = 8'h00;
        wr(12'h204, 32'd2);

        // Threshold boundary and priority-0 source
        wr(12'h010, 32'd1);
        wr(12'h100, 32'h10);
        irq_src_i = 8'h08;
        rd_chk("pending_src4", 12'h080, 32'h10);
        check("irq_at_threshold", {31'd0, irq_o}, 32'd0);
        wr(12'h200, 32'd0);
        check("irq_thr_write_edge", {31'd0, irq_o}, 32'd0);
        @(posedge clk_i); #1;
        check("irq_thr_next", {31'd0, irq_o}, 32'd1);
        rd_chk("claim_4", 12'h204, 32'd4);
        wr(12'h100, 32'h40);
        irq_src_i = 8'h28;
        rd_chk("pending_src6", 12'h080, 32'h40);
        check("irq_prio0", {31'd0, irq_o}, 32'd0);
        rd_chk("claim_prio0_none", 12'h204, 32'd0);
        rd_chk("pending_after_empty_claim", 12'h080, 32'h40);
        wr(12'h01C, 32'hFFFF_FFFF);
        rd_chk("prio7_width", 12'h01C, 32'd7);

        // Unmapped and read-only accesses
        apb_write(12'h080, 32'hFF, e);
        check("slverr_ro_write", {31'd0, e}, {31'd0, ExpErr});
        rd_chk("pending_after_ro_write", 12'h080, 32'h40);
        apb_read(12'h300, d, e);
        check("unmapped_rdata", d, 32'd0);
        check("slverr_unmapped", {31'd0, e}, {31'd0, ExpErr});
        apb_read(12'h024, d, e);
        check("prio9_rdata", d, 32'd0);
        check("slverr_prio9", {31'd0, e}, {31'd0, ExpErr});
        apb_write(12'h000, 32'd7, e);
        check("slverr_prio0_write", {31'd0, e}, 32'd0);
        rd_chk("prio0_reads_zero", 12'h000, 32'd0);

        // Reset in the middle of a read access
        psel_i = 1'b1; penable_i = 1'b1; pwrite_i = 1'b0; paddr_i = 12'h080;
        rst_i = 1'b1;
        #1;
        check("prdata_in_reset", prdata_o, 32'd0);
        check("slverr_in_reset", {31'd0, pslverr_o}, 32'd0);
        @(posedge clk_i); #1;
        check("irq_in_reset", {31'd0, irq_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
        rd_chk("pending_repend_after_reset", 12'h080, 32'h50);
        rd_chk("prio4_after_reset", 12'h010, 32'd0);
        rd_chk("enable_after_reset", 12'h100, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_plic_target.md
APB_PLIC_TARGET -- requirements
Module: apb_plic_target

Interface
REQ-001 SHALL have parameter NIrqSrcs, default 8, number of interrupt sources (legal 1..31); source IDs are 1..NIrqSrcs, and ID 0 means "none".
REQ-002 SHALL have parameter PrioWidth, default 3, width of each source priority and of the threshold.
REQ-003 clk_i  input  1  single clock; all logic is on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 psel_i  input  1  APB select.
REQ-006 penable_i  input  1  APB enable (access phase).
REQ-007 pwrite_i  input  1  APB write (1) / read (0).
REQ-008 paddr_i  input  12  APB byte address; bits [1:0] ignored.
REQ-009 pwdata_i  input  32  APB write data.
REQ-010 prdata_o  output  32  APB read data.
REQ-011 pready_o  output  1  APB ready.
REQ-012 pslverr_o  output  1  APB error.
REQ-013 irq_src_i  input  NIrqSrcs  level interrupt sources; bit k-1 is source ID k.
REQ-014 irq_o  output  1  registered interrupt request to the hart context.

Function
REQ-015 SHALL be an APB3 completer: an access is psel_i & penable_i; pready_o SHALL be 1 (zero wait states), and every side effect SHALL occur only in the access cycle.
REQ-016 Register map: 0x000+4*k = priority[k] (RW, k=1..N; k=0 reads 0, writes ignored); 0x080 = pending bitmap, bit k = ID k (RO); 0x100 = enable bitmap (RW, bit 0 reads 0); 0x200 = threshold (RW); 0x204 = claim (read) / complete (write).
REQ-017 Unused upper bits SHALL read 0; prdata_o SHALL be 0 outside read access cycles.
REQ-018 Gateway per source: pending[k] SHALL be set on the clock edge where irq_src_i[k-1]=1, pending[k]=0 and inflight[k]=0.
REQ-019 Winner: the enabled, pending source with priority > threshold and the highest priority; ties go to the lowest ID; priority 0 never wins.
REQ-020 irq_o SHALL register "winner exists".
REQ-021 Latency: the source rises at edge N, pending is set at edge N, and irq_o is 1 after edge N+1.
REQ-022 Claim read SHALL return the winner ID combinationally in the access cycle; on that edge it SHALL clear pending[ID] and set inflight[ID].
REQ-023 Claim read with no winner SHALL return 0 and change no state.
REQ-024 Complete write of ID k with inflight[k]=1 SHALL clear inflight[k].
REQ-025 Complete write of 0, of an out-of-range ID, or of a non-inflight ID SHALL be ignored.
REQ-026 Simultaneous claim and source assertion on the same ID: the claim wins, and pending stays 0 because inflight is now set.
REQ-027 Simultaneous events on different IDs SHALL all take effect on the same edge.
REQ-028 Simultaneous complete of ID k with irq_src_i[k-1]=1: inflight clears on that edge, and pending sets on the following edge.
REQ-029 Writes to priority, enable or threshold SHALL affect winner selection from the next cycle.

Reset
REQ-030 While rst_i=1 at an edge, all priority, enable, threshold, pending and inflight state SHALL go to 0, and irq_o SHALL be 0.
REQ-031 prdata_o and pslverr_o SHALL be 0 during reset; pready_o SHALL stay 1.
REQ-032 Reset during an APB access SHALL abandon its side effects; claims in flight are lost, and sources re-pend after reset if still asserted.

Configuration
REQ-033 Macro APB_PLIC_SLVERR_EN defined: an access to an unmapped address, or a write to a RO register, SHALL assert pslverr_o in the access cycle, with no state change and read data 0.
REQ-034 Macro APB_PLIC_SLVERR_EN undefined: pslverr_o SHALL be tied 0; such accesses read 0 and writes are ignored.

Verification
REQ-035 Reset, then read all registers -> all return 0; irq_o=0; pready_o=1.
REQ-036 Set priority[3]=2, enable=0x08, threshold=1; raise irq_src_i[2] at edge N -> pending reads 0x08; irq_o=1 after edge N+1; claim read returns 3; pending=0; irq_o=0 two cycles later.
REQ-037 Set priority[1]=priority[5]=4 and priority[2]=6, enable=0x26, all three sources high -> claims return 2, 1, 5 in order, then 0.
REQ-038 Hold source 3 high after its claim -> no re-pend; complete write of 3 -> pending[3] set next edge; complete writes of 0 and 7 (not inflight) -> no change.
REQ-039 Priority[4]=1 with threshold=1 -> no irq_o; write threshold=0 -> irq_o=1 next-but-one cycle.
REQ-040 With APB_PLIC_SLVERR_EN: write 0x080 and read 0x300 -> pslverr_o=1 and pending unchanged; without the macro -> pslverr_o=0.
